// File: rtl/riscv_mem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter.
package riscv_mem_arbiter_pkg;

  localparam int unsigned DEF_ADDR_W         = 32;
  localparam int unsigned DEF_DATA_W         = 32;
  localparam int unsigned DEF_MAX_D_STREAK   = 4;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 16;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_BUSY_IF = 2'd1;
  localparam state_t ST_BUSY_D  = 2'd2;
  localparam state_t ST_DONE    = 2'd3;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

endpackage

// File: rtl/riscv_arb_watchdog.sv
// Counts cycles of an outstanding memory transaction; flags the cycle in which
// the count reaches the timeout limit.
module riscv_arb_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired_c
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  // True on the cycle whose increment brings the count to the limit.
  assign expired_c = enable && (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Arbitrates one single-port memory between the fetch and load/store ports,
// data first with a bounded streak, plus a timeout that forces an error completion.
module riscv_mem_arbiter
  import riscv_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W         = DEF_ADDR_W,
  parameter int unsigned DATA_W         = DEF_DATA_W,
  parameter int unsigned MAX_D_STREAK   = DEF_MAX_D_STREAK,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              bus_err
);

  localparam int unsigned STRK_W = $clog2(MAX_D_STREAK + 1);

  state_t            state;
  state_t            state_nxt;
  owner_e            owner;
  logic [STRK_W-1:0] streak;
  logic [STRK_W-1:0] streak_nxt;
  logic              busy;
  logic              expired;
  logic              grant_d;
  logic              grant_if;
  logic              complete;
  logic [DATA_W-1:0] cpl_data;

  logic              mem_req_nxt;
  logic              mem_we_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic [DATA_W-1:0] mem_wdata_nxt;
  logic              if_ready_nxt;
  logic              d_ready_nxt;
  logic [DATA_W-1:0] if_rdata_nxt;
  logic [DATA_W-1:0] d_rdata_nxt;
  logic              bus_err_nxt;

  assign busy     = (state == ST_BUSY_IF) || (state == ST_BUSY_D);
  assign owner    = (state == ST_BUSY_D) ? OWN_D : OWN_IF;
  assign complete = busy && (mem_ack || expired);
  // A timeout completes with zero data; a same-cycle ack takes precedence.
  assign cpl_data = mem_ack ? mem_rdata : '0;

  // Data wins unless fetch is waiting and data has used its whole streak.
  assign grant_d  = d_req && (!if_req || (streak < STRK_W'(MAX_D_STREAK)));
  assign grant_if = if_req && !grant_d;

  riscv_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .clear    (state == ST_DONE),
    .enable   (busy),
    .expired_c(expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (grant_d) begin
          state_nxt = ST_BUSY_D;
        end else if (grant_if) begin
          state_nxt = ST_BUSY_IF;
        end
      end
      ST_BUSY_IF, ST_BUSY_D: begin
        if (complete) begin
          state_nxt = ST_DONE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_req_nxt   = mem_req;
    mem_we_nxt    = mem_we;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    if_rdata_nxt  = if_rdata;
    d_rdata_nxt   = d_rdata;
    if_ready_nxt  = 1'b0;
    d_ready_nxt   = 1'b0;
    bus_err_nxt   = 1'b0;
    streak_nxt    = streak;
    case (state)
      ST_IDLE: begin
        if (grant_d) begin
          mem_req_nxt   = 1'b1;
          mem_we_nxt    = d_we;
          mem_addr_nxt  = d_addr;
          mem_wdata_nxt = d_wdata;
          if (!if_req) begin
            streak_nxt = '0;
          end else if (streak != STRK_W'(MAX_D_STREAK)) begin
            streak_nxt = streak + STRK_W'(1);
          end
        end else if (grant_if) begin
          mem_req_nxt  = 1'b1;
          mem_we_nxt   = 1'b0;
          mem_addr_nxt = if_addr;
          streak_nxt   = '0;
        end
      end
      ST_BUSY_IF, ST_BUSY_D: begin
        if (complete) begin
          mem_req_nxt = 1'b0;
          bus_err_nxt = !mem_ack;
          if (owner == OWN_D) begin
            d_rdata_nxt = cpl_data;
            d_ready_nxt = 1'b1;
          end else begin
            if_rdata_nxt = cpl_data;
            if_ready_nxt = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_ready  <= 1'b0;
      d_ready   <= 1'b0;
      bus_err   <= 1'b0;
      streak    <= '0;
    end else begin
      mem_req   <= mem_req_nxt;
      mem_we    <= mem_we_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      if_rdata  <= if_rdata_nxt;
      d_rdata   <= d_rdata_nxt;
      if_ready  <= if_ready_nxt;
      d_ready   <= d_ready_nxt;
      bus_err   <= bus_err_nxt;
      streak    <= streak_nxt;
    end
  end

endmodule

// File: doc/riscv_mem_arbiter.md
Name: riscv_mem_arbiter

Overview:
- Shares one single-port memory between the core's instruction-fetch port and its load/store data port.
- Uses a request/ready handshake toward each requester and a req/ack handshake toward memory.
- Data accesses take priority, with a bounded-streak fairness rule so fetch is never starved.
- A watchdog converts a stuck memory transaction into an error completion.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- MAX_D_STREAK, 4, max consecutive data grants while a fetch is pending.
- TIMEOUT_CYCLES, 16, cycles in BUSY without mem_ack before an error completion.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held until if_ready.
- if_addr  in  ADDR_W  fetch address (the core's pc).
- if_ready  out  1  one-cycle fetch completion pulse.
- if_rdata  out  DATA_W  fetched instruction; valid while if_ready.
- d_req  in  1  data request; held until d_ready.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address (the ALU result).
- d_wdata  in  DATA_W  store data.
- d_ready  out  1  one-cycle data completion pulse.
- d_rdata  out  DATA_W  load data; valid while d_ready.
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_ack  in  1  memory completion; mem_rdata valid in the same cycle.
- mem_rdata  in  DATA_W  memory read data.
- bus_err  out  1  one-cycle pulse on a watchdog timeout.

Behaviour:
- Reset (asynchronous, immediate):
  - State = IDLE.
  - All outputs 0, including mem_req, if_ready, d_ready, bus_err, rdata buses and mem_* buses.
  - Streak and timeout counters = 0.
  - Reset asserted mid-transaction abandons it; no ready pulse is produced.
- States: IDLE, BUSY_IF, BUSY_D, DONE.
- IDLE:
  - If d_req is high and (if_req is low or streak < MAX_D_STREAK): latch d_we, d_addr, d_wdata into mem_*; go to BUSY_D. Streak increments (saturating) if if_req is high, else clears to 0.
  - Else if if_req is high: latch if_addr into mem_addr with mem_we = 0; go to BUSY_IF; streak clears to 0.
  - Else stay in IDLE.
- BUSY_*:
  - mem_req = 1; mem_* stay stable and ignore requester changes.
  - Timeout counter increments each cycle.
  - On mem_ack: capture mem_rdata into the owner's rdata register; go to DONE.
  - If the counter reaches TIMEOUT_CYCLES without mem_ack: rdata register = 0; bus_err pulses in the DONE cycle; go to DONE.
  - mem_ack in the same cycle as the timeout: the ack wins and no error is raised.
- DONE:
  - mem_req = 0; the owner's ready = 1 for exactly this cycle.
  - Timeout counter clears; go to IDLE.
- Latency: request seen in IDLE at cycle 0 → mem_req from cycle 1. Ack at cycle k ≥ 1 → ready at cycle k+1.
- Back-to-back: the next grant is decided in IDLE at cycle k+2. Requesters must drop or renew req in the cycle after ready; a req still high in IDLE is treated as a new request.
- rdata registers hold their value after ready until the next completion for that port.
- For stores, d_rdata is the value on mem_rdata at ack (don't-care).
- mem_ack outside BUSY_* is ignored.

Decomposition:
- Shared package holds:
  - State encoding constants ST_IDLE=2'd0, ST_BUSY_IF=2'd1, ST_BUSY_D=2'd2, ST_DONE=2'd3.
  - An owner enum (OWN_IF, OWN_D).
  - Default widths.
- One natural sub-module: riscv_arb_watchdog, the timeout counter with clear/enable inputs and an expired output.
- Arbitration and the FSM stay in the top module.

Test Plan:
- Single fetch: if_req=1, if_addr=0x100; mem acks 2 cycles after mem_req with rdata=0x00A00093 → mem_addr=0x100, mem_we=0; if_ready pulses 3 cycles after mem_req rise with if_rdata=0x00A00093.
- Simultaneous: if_req and d_req (store, d_addr=0x40, d_wdata=0x1234) raised in the same cycle → data granted first (mem_we=1, mem_wdata=0x1234). Fetch is granted after d_ready.
- Starvation: d_req held continuously, if_req held, ack in 1 cycle → exactly 4 data grants, then a fetch grant, then data resumes.
- Timeout: grant a load at 0x80 with mem_ack never asserted → bus_err and d_ready pulse together 17 cycles after the grant, d_rdata=0, then IDLE.
- Reset mid-transaction: reset asserted during BUSY_D → mem_req drops asynchronously, no d_ready. After release, a pending if_req is granted normally.
- Ack/timeout race: mem_ack arrives on the cycle the counter reaches 16 → normal completion with captured rdata, bus_err=0.
